dffram_arbiter: RTL and testbench

- Shares one single-port, 4096x32, byte-masked synchronous SRAM macro between two requesters: port 0 (instruction fetch) and port 1 (data load/store).
- One access is issued to the RAM per cycle, selected by round-robin arbitration.
- Each granted access returns exactly one response one cycle later, routed back to the requester that issued it.
- The block sits between the core-side memory adapters and the SRAM macro.

---
 rtl/dffram_arbiter.sv | 123 ++++++++++++
 tb/tb_dffram_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dffram_arbiter.sv
// Round-robin arbiter sharing one byte-masked sync SRAM
// between an instruction port (0) and a data port (1).
//
// Ports:
//   clk_i, rst_i          clock, sync active-high reset
//   req_i[1:0]            per-port request valid
//   addrN_i, weN_i        word address, write enable
//   beN_i, wdataN_i       byte enables, write data
//   gnt_o[1:0]            combinational grant (one-hot/zero)
//   rvalid_o, err_o       per-port response, one cycle later
//   rdata_o               shared response data
//   ram_en_o, ram_we_o    SRAM enable, byte write mask
//   ram_a_o, ram_di_o     SRAM address, write data
//   ram_do_i              SRAM read data (cycle after enable)
module dffram_arbiter #(
  parameter int AW    = 12,
  parameter int DW    = 32,
  parameter int DEPTH = 4096
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [1:0]      req_i,
  input  logic [AW-1:0]   addr0_i,
  input  logic [AW-1:0]   addr1_i,
  input  logic            we0_i,
  input  logic            we1_i,
  input  logic [DW/8-1:0] be0_i,
  input  logic [DW/8-1:0] be1_i,
  input  logic [DW-1:0]   wdata0_i,
  input  logic [DW-1:0]   wdata1_i,
  output logic [1:0]      gnt_o,
  output logic [1:0]      rvalid_o,
  output logic [DW-1:0]   rdata_o,
  output logic [1:0]      err_o,
  output logic            ram_en_o,
  output logic [DW/8-1:0] ram_we_o,
  output logic [AW-1:0]   ram_a_o,
  output logic [DW-1:0]   ram_di_o,
  input  logic [DW-1:0]   ram_do_i
);

  localparam int BW = DW / 8;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic            last_q, last_d;
  logic [1:0]      rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic            rsp_wr_q, rsp_wr_d;

  logic [1:0]      gnt;
  logic            any_gnt;
  logic            sel;
  logic [AW-1:0]   sel_addr;
  logic            sel_we;
  logic [BW-1:0]   sel_be;
  logic [DW-1:0]   sel_wdata;
  logic            oor;

  wire both  = req_i == 2'b11;
  wire only0 = req_i == 2'b01;
  wire only1 = req_i == 2'b10;

  always_comb begin
    gnt = 2'b00;
    if (!rst_i) begin
      unique case (1'b1)
        both:    gnt = last_q ? 2'b01 : 2'b10;
        only0:   gnt = 2'b01;
        only1:   gnt = 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign gnt_o   = gnt;
  assign any_gnt = |gnt;
  assign sel     = gnt[1];

  assign sel_addr  = sel ? addr1_i  : addr0_i;
  assign sel_we    = sel ? we1_i    : we0_i;
  assign sel_be    = sel ? be1_i    : be0_i;
  assign sel_wdata = sel ? wdata1_i : wdata0_i;

  assign oor = {1'b0, sel_addr} >= DEPTH_W;

  // Out-of-range accesses are granted but never reach the macro.
  assign ram_en_o = any_gnt & ~oor;
  assign ram_we_o = (ram_en_o && sel_we) ? sel_be : '0;
  assign ram_a_o  = any_gnt ? sel_addr  : '0;
  assign ram_di_o = any_gnt ? sel_wdata : '0;

  always_comb begin
    last_d      = any_gnt ? sel : last_q;
    rsp_valid_d = gnt;
    rsp_err_d   = any_gnt & oor;
    rsp_wr_d    = any_gnt & sel_we;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q      <= 1'b1;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 1'b0;
      rsp_wr_q    <= 1'b0;
    end else begin
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_wr_q    <= rsp_wr_d;
    end
  end

  // Responses are masked while reset is held so an access
  // granted just before reset is squashed immediately.
  logic rsp_live;
  assign rsp_live = ~rst_i & |rsp_valid_q;

  assign rvalid_o = rsp_live ? rsp_valid_q : 2'b00;
  assign err_o    = (rsp_live && rsp_err_q) ? rsp_valid_q : 2'b00;
  assign rdata_o  = (rsp_live && !rsp_err_q && !rsp_wr_q)
                  ? ram_do_i : '0;

endmodule

// File: tb/tb_dffram_arbiter.sv
// Self-checking bench for dffram_arbiter with a byte-masked
// SRAM model and an in-order response scoreboard.
module tb_dffram_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int DEPTH = 4000;

  logic          clk;
  logic          rst;
  logic [1:0]    req;
  logic [AW-1:0] addr0, addr1;
  logic          we0, we1;
  logic [3:0]    be0, be1;
  logic [DW-1:0] wd0, wd1;
  logic [1:0]    gnt_o, rvalid_o, err_o;
  logic [DW-1:0] rdata_o;
  logic          ram_en_o;
  logic [3:0]    ram_we_o;
  logic [AW-1:0] ram_a_o;
  logic [DW-1:0] ram_di_o;
  logic [DW-1:0] ram_do;

  logic          pl_en;
  logic [AW-1:0] pl_a;
  logic [DW-1:0] pl_d;

  int total;
  int bad;

  typedef struct {
    logic [1:0]  port;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];

  logic [31:0] sram    [4096];
  logic [31:0] ref_mem [4096];

  dffram_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req),
    .addr0_i (addr0),
    .addr1_i (addr1),
    .we0_i   (we0),
    .we1_i   (we1),
    .be0_i   (be0),
    .be1_i   (be1),
    .wdata0_i(wd0),
    .wdata1_i(wd1),
    .gnt_o   (gnt_o),
    .rvalid_o(rvalid_o),
    .rdata_o (rdata_o),
    .err_o   (err_o),
    .ram_en_o(ram_en_o),
    .ram_we_o(ram_we_o),
    .ram_a_o (ram_a_o),
    .ram_di_o(ram_di_o),
    .ram_do_i(ram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro model
  always @(posedge clk) begin
    if (pl_en) begin
      sram[pl_a] <= pl_d;
    end else if (ram_en_o) begin
      if (ram_we_o == 4'b0000) begin
        ram_do <= sram[ram_a_o];
      end else begin
        for (int b = 0; b < 4; b++)
          if (ram_we_o[b])
            sram[ram_a_o][b*8 +: 8] <= ram_di_o[b*8 +: 8];
      end
    end
  end

  // Scoreboard: expectations pushed at grant, checked next cycle
  always @(negedge clk) begin
    exp_t e;
    logic [AW-1:0] a;
    logic          w;
    logic [3:0]    be;
    logic [31:0]   d;
    logic [1:0]    experr;
    if (pl_en) ref_mem[pl_a] = pl_d;
    if (rst) begin
      q.delete();
      total++;
      if (rvalid_o !== 2'b00 || err_o !== 2'b00) begin
        bad++;
        $display("FAIL rst_rsp rvalid=%b err=%b exp=00/00",
                 rvalid_o, err_o);
      end
    end else begin
      if (q.size() > 0) begin
        e = q.pop_front();
        experr = e.err ? e.port : 2'b00;
        total++;
        if (rvalid_o !== e.port || err_o !== experr ||
            rdata_o !== e.data) begin
          bad++;
          $display("FAIL sb_rsp got v=%b e=%b d=%h exp v=%b e=%b d=%h",
                   rvalid_o, err_o, rdata_o, e.port, experr, e.data);
        end
      end else begin
        total++;
        if (rvalid_o !== 2'b00) begin
          bad++;
          $display("FAIL sb_idle rvalid=%b exp=00", rvalid_o);
        end
      end
      if (gnt_o != 2'b00) begin
        a  = gnt_o[1] ? addr1 : addr0;
        w  = gnt_o[1] ? we1   : we0;
        be = gnt_o[1] ? be1   : be0;
        d  = gnt_o[1] ? wd1   : wd0;
        e.port = gnt_o;
        e.err  = 1'b0;
        e.data = 32'h0;
        if (int'(a) >= DEPTH) begin
          e.err = 1'b1;
        end else if (w) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
        end else begin
          e.data = ref_mem[a];
        end
        q.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a,
                         input logic [31:0] d);
    pl_en = 1'b1;
    pl_a  = a;
    pl_d  = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    req = 2'b00;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req = 2'b11;
    @(negedge clk);
    total++;
    if (gnt_o !== 2'b00 || ram_en_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_gnt gnt=%b en=%b exp=00/0",
               gnt_o, ram_en_o);
    end
    total++;
    if (rdata_o !== 32'h0 || err_o !== 2'b00) begin
      bad++;
      $display("FAIL reset_out rdata=%h err=%b exp=0/00",
               rdata_o, err_o);
    end
    step();
    req = 2'b00;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (rvalid_o !== 2'b00 || gnt_o !== 2'b00) begin
      bad++;
      $display("FAIL post_reset rvalid=%b gnt=%b exp=00/00",
               rvalid_o, gnt_o);
    end
    step();
  endtask

  task automatic test_read();
    req = 2'b01; addr0 = 12'h000; we0 = 1'b0;
    @(negedge clk);
    total++;
    if (gnt_o !== 2'b01 || ram_en_o !== 1'b1) begin
      bad++;
      $display("FAIL read_gnt gnt=%b en=%b exp=01/1",
               gnt_o, ram_en_o);
    end
    step();
    req = 2'b00;
    @(negedge clk);
    total++;
    if (rvalid_o !== 2'b01 || rdata_o !== 32'h400C0437 ||
        err_o !== 2'b00) begin
      bad++;
      $display("FAIL read_rsp v=%b d=%h e=%b exp 01/400c0437/00",
               rvalid_o, rdata_o, err_o);
    end
    step();
  endtask

  task automatic test_byte_write();
    req = 2'b10; addr1 = 12'h010; we1 = 1'b1;
    be1 = 4'b0101; wd1 = 32'hDEADBEEF;
    @(negedge clk);
    total++;
    if (gnt_o !== 2'b10 || ram_we_o !== 4'b0101 ||
        ram_di_o !== 32'hDEADBEEF || ram_a_o !== 12'h010) begin
      bad++;
      $display("FAIL wr_drive gnt=%b we=%b di=%h a=%h",
               gnt_o, ram_we_o, ram_di_o, ram_a_o);
    end
    step();
    we1 = 1'b0;
    @(negedge clk);
    total++;
    if (gnt_o !== 2'b10 || ram_we_o !== 4'b0000) begin
      bad++;
      $display("FAIL rd_drive gnt=%b we=%b exp=10/0000",
               gnt_o, ram_we_o);
    end
    total++;
    if (rvalid_o !== 2'b10 || rdata_o !== 32'h0) begin
      bad++;
      $display("FAIL wr_rsp v=%b d=%h exp=10/0", rvalid_o, rdata_o);
    end
    step();
    req = 2'b00;
    @(negedge clk);
    total++;
    if (rvalid_o !== 2'b10 || rdata_o !== 32'h11AD33EF) begin
      bad++;
      $display("FAIL merge_rd v=%b d=%h exp=10/11ad33ef",
               rvalid_o, rdata_o);
    end
    step();
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    reset_pulse();
    req = 2'b11; we0 = 1'b0; we1 = 1'b0;
    addr0 = 12'h020; addr1 = 12'h021;
    for (int i = 0; i < 6; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      total++;
      if (gnt_o !== exp_g) begin
        bad++;
        $display("FAIL contend_%0d gnt=%b exp=%b", i, gnt_o, exp_g);
      end
      step();
    end
    req = 2'b00;
    step();
  endtask

  task automatic test_oor();
    req = 2'b10; addr1 = 12'hFFF; we1 = 1'b0;
    @(negedge clk);
    total++;
    if (gnt_o !== 2'b10 || ram_en_o !== 1'b0) begin
      bad++;
      $display("FAIL oor_rd gnt=%b en=%b exp=10/0", gnt_o, ram_en_o);
    end
    step();
    addr1 = 12'd4000; we1 = 1'b1; be1 = 4'hF; wd1 = 32'h12345678;
    @(negedge clk);
    total++;
    if (gnt_o !== 2'b10 || ram_en_o !== 1'b0 ||
        ram_we_o !== 4'b0000) begin
      bad++;
      $display("FAIL oor_wr gnt=%b en=%b we=%b exp=10/0/0000",
               gnt_o, ram_en_o, ram_we_o);
    end
    total++;
    if (rvalid_o !== 2'b10 || err_o !== 2'b10 ||
        rdata_o !== 32'h0) begin
      bad++;
      $display("FAIL oor_rsp v=%b e=%b d=%h exp=10/10/0",
               rvalid_o, err_o, rdata_o);
    end
    step();
    addr1 = 12'd3999; we1 = 1'b0;
    @(negedge clk);
    total++;
    if (gnt_o !== 2'b10 || ram_en_o !== 1'b1) begin
      bad++;
      $display("FAIL edge_rd gnt=%b en=%b exp=10/1", gnt_o, ram_en_o);
    end
    step();
    req = 2'b00;
    @(negedge clk);
    total++;
    if (err_o !== 2'b00 || rdata_o !== 32'h0F9F0F9F) begin
      bad++;
      $display("FAIL edge_rsp e=%b d=%h exp=00/0f9f0f9f",
               err_o, rdata_o);
    end
    step();
  endtask

  task automatic test_reset_squash();
    reset_pulse();
    req = 2'b01; addr0 = 12'h000; we0 = 1'b0;
    @(negedge clk);
    total++;
    if (gnt_o !== 2'b01) begin
      bad++;
      $display("FAIL sq_gnt gnt=%b exp=01", gnt_o);
    end
    step();
    req = 2'b00; rst = 1'b1;
    @(negedge clk);
    total++;
    if (rvalid_o !== 2'b00) begin
      bad++;
      $display("FAIL sq_t1 rvalid=%b exp=00", rvalid_o);
    end
    step();
    rst = 1'b0; req = 2'b11; addr1 = 12'h021; we1 = 1'b0;
    @(negedge clk);
    total++;
    if (gnt_o !== 2'b01 || rvalid_o !== 2'b00) begin
      bad++;
      $display("FAIL sq_t2 gnt=%b rvalid=%b exp=01/00",
               gnt_o, rvalid_o);
    end
    step();
    req = 2'b00;
    step();
  endtask

  task automatic test_starve();
    logic [1:0] exp_g;
    reset_pulse();
    req = 2'b01; addr0 = 12'h020; addr1 = 12'h021;
    we0 = 1'b0; we1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (gnt_o !== 2'b01) begin
        bad++;
        $display("FAIL solo_%0d gnt=%b exp=01", i, gnt_o);
      end
      step();
    end
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      @(negedge clk);
      total++;
      if (gnt_o !== exp_g) begin
        bad++;
        $display("FAIL join_%0d gnt=%b exp=%b", i, gnt_o, exp_g);
      end
      step();
    end
    req = 2'b00;
    step();
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    req   = 2'b00;
    addr0 = '0; addr1 = '0;
    we0   = 1'b0; we1 = 1'b0;
    be0   = 4'h0; be1 = 4'h0;
    wd0   = '0; wd1 = '0;
    pl_en = 1'b0; pl_a = '0; pl_d = '0;
    step();
    preload(12'h000, 32'h400C0437);
    preload(12'h010, 32'h11223344);
    preload(12'h020, 32'hA0A0A020);
    preload(12'h021, 32'hB1B1B121);
    preload(12'hF9F, 32'h0F9F0F9F);
    test_reset();
    test_read();
    test_byte_write();
    test_contention();
    test_oor();
    test_reset_squash();
    test_starve();
    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain left=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
